// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer granting a 4:1 bit mux to one requester per bounded burst.
// Latency: grant one edge after a request is seen in IDLE; first beat one edge after grant; all outputs registered.
// Backpressure: owner holds the channel while req[owner] stays high (max MAX_BURST beats); dropping req ends the burst.
module mux_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] gnt,
    output logic       address0,
    output logic       address1,
    output logic       out,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Final beat index of a full burst; the counter counts beats already taken.
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic [3:0] din;
    logic [1:0] winner;
    logic       win_vld;
    logic [1:0] idx;

    // Round-robin search starting at ptr; scanning downwards leaves the closest requester as winner.
    always_comb begin
        din     = {in3, in2, in1, in0};
        winner  = ptr_q;
        win_vld = 1'b0;
        idx     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic; defaults hold everything except the beat strobe.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    out_d       = din[owner_q];
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                end
                // Release on a dropped request or after the last allowed beat.
                if (!req[owner_q] || (cnt_q == LAST_BEAT)) begin
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd0;
            cnt_q       <= 4'd0;
            gnt_q       <= 4'b0000;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign address0  = owner_q[0];
    assign address1  = owner_q[1];
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == GRANT) || (state_q == GAP);

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
    logic [3:0] gnt;
    logic       address0, address1, out, out_valid, busy;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the channel (-1 = nobody), turnaround flag, pointer, beats taken
    int m_owner, m_ptr, m_beats, m_addr;
    bit m_gap, m_out, m_vld;

    mux_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt), .address0(address0), .address1(address1),
        .out(out), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] m_gnt();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    function automatic logic m_busy();
        return (m_owner >= 0) || m_gap;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_addr = 0;
        m_gap = 0; m_out = 0; m_vld = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [3:0] d;
        int w;
        d = {in3, in2, in1, in0};
        if (m_owner >= 0) begin
            bit rel;
            rel = 0;
            if (req[m_owner]) begin
                m_out = d[m_owner];
                m_vld = 1;
                m_beats++;
                if (m_beats == MB) rel = 1;
            end else begin
                m_vld = 0;
                rel = 1;
            end
            if (rel) begin
                m_ptr = (m_owner + 1) % 4;
                m_gap = 1;
                m_owner = -1;
            end
        end else if (m_gap) begin
            m_vld = 0;
            m_gap = 0;
        end else begin
            m_vld = 0;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (w >= 0) begin
                m_owner = w; m_addr = w; m_beats = 0;
            end
        end
    endtask

    // One rising edge; returns at the following falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000; {in3, in2, in1, in0} = 4'b0000;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, address1, address0, out, out_valid, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_values: got gnt=%b a1=%b a0=%b out=%b vld=%b busy=%b, want all zero",
                     gnt, address1, address0, out, out_valid, busy);
        end
        req = 4'b0100; in2 = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preburst: got gnt=%b vld=%b, want 0100/1", gnt, out_valid);
        end
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, address1, address0, out_valid, busy} !== 8'b0) begin
            errors++;
            $display("FAIL reset_midburst: got gnt=%b a1=%b a0=%b vld=%b busy=%b, want zeros",
                     gnt, address1, address0, out_valid, busy);
        end
        #1 reset_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0100 || {address1, address0} !== 2'b10) begin
            errors++;
            $display("FAIL reset_regrant: got gnt=%b addr=%b%b, want 0100 addr=10", gnt, address1, address0);
        end
    endtask

    task automatic test_full_burst();
        logic [4:0] pat;
        int beats;
        logic [3:0] got;
        pat = 5'b11101; // bit b is the value for the b-th data edge: 1,0,1,1,1
        beats = 0; got = 4'b0;
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || address0 !== 1'b1 || address1 !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_grant: got gnt=%b a1=%b a0=%b vld=%b, want 0010 a1=0 a0=1 vld=0",
                     gnt, address1, address0, out_valid);
        end
        for (int b = 0; b < 6; b++) begin
            in1 = pat[(b < 5) ? b : 4];
            tick();
            if (out_valid) begin
                if (beats < 4) got[beats] = out;
                beats++;
            end
            if (b == 3) begin
                checks++;
                if (gnt !== 4'b0000 || busy !== 1'b1 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_release: got gnt=%b busy=%b vld=%b, want 0000/1/1", gnt, busy, out_valid);
                end
            end
            if (b == 4) begin
                checks++;
                if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_gap: got gnt=%b vld=%b, want 0000/0", gnt, out_valid);
                end
            end
        end
        checks++;
        if (beats != 4 || got !== 4'b1101) begin
            errors++;
            $display("FAIL burst_beats: got %0d beats data=%b, want 4 beats data=1101 (lsb first)", beats, got);
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL burst_regrant: got gnt=%b, want 0010 two edges after release", gnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int nv;
            logic [3:0] eg;
            logic [1:0] ea;
            eg = 4'(1 << (g % 4));
            ea = 2'(g % 4);
            tick();
            checks++;
            if (gnt !== eg || {address1, address0} !== ea) begin
                errors++;
                $display("FAIL rr_grant%0d: got gnt=%b addr=%b%b, want %b addr=%b", g, gnt, address1, address0, eg, ea);
            end
            nv = 0;
            for (int b = 0; b < MB; b++) begin
                tick();
                if (out_valid) nv++;
            end
            tick();
            checks++;
            if (nv != MB || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_burst%0d: got %0d beats busy=%b vld=%b, want %0d beats idle", g, nv, busy, out_valid, MB);
            end
        end
    endtask

    task automatic test_early_release();
        int nv;
        nv = 0;
        do_reset();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || {address1, address0} !== 2'b11) begin
            errors++;
            $display("FAIL early_grant: got gnt=%b addr=%b%b, want 1000 addr=11", gnt, address1, address0);
        end
        for (int b = 0; b < 2; b++) begin
            tick();
            if (out_valid) nv++;
        end
        req = 4'b0001;
        tick();
        if (out_valid) nv++;
        checks++;
        if (nv != 2 || gnt !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_release: got %0d beats gnt=%b busy=%b, want 2 beats 0000 busy=1", nv, gnt, busy);
        end
        req = 4'b1001;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL early_next: got gnt=%b, want 0001", gnt);
        end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req = 4'b0100; tick();
        req = 4'b0000; tick(); tick();
        req = 4'b0100; tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL skip_grant: got gnt=%b, want 0100", gnt);
        end
        req = 4'b0000; tick(); tick();
        req = 4'b0101; tick();
        checks++;
        if (gnt !== 4'b0001 || {address1, address0} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_grant: got gnt=%b addr=%b%b, want 0001 addr=00", gnt, address1, address0);
        end
    endtask

    task automatic test_data_select();
        do_reset();
        {in3, in2, in1, in0} = 4'b0001;
        req = 4'b0001; tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 1'b1) begin
            errors++;
            $display("FAIL sel_owner0: got out=%b vld=%b, want 1/1", out, out_valid);
        end
        req = 4'b0000; tick(); tick();
        req = 4'b0010; tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 1'b0 || address0 !== 1'b1) begin
            errors++;
            $display("FAIL sel_owner1: got out=%b vld=%b a0=%b, want 0/1/1", out, out_valid, address0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) | ($urandom_range(0, 3) == 0 ? 4'hF : 4'h0));
            {in3, in2, in1, in0} = 4'($urandom);
            tick();
            checks++;
            if ({gnt, address1, address0, busy, out_valid} !== {m_gnt(), 2'(m_addr), m_busy(), m_vld}) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: got gnt=%b addr=%b%b busy=%b vld=%b, want gnt=%b addr=%0d busy=%b vld=%b",
                         c, gnt, address1, address0, busy, out_valid, m_gnt(), m_addr, m_busy(), m_vld);
            end
            if (m_vld) begin
                checks++;
                if (out !== m_out) begin
                    errors++;
                    $display("FAIL rand_data@%0d: got out=%b, want %b", c, out, m_out);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_burst();
        test_round_robin();
        test_early_release();
        test_skip_wrap();
        test_data_select();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
